instr_fetch_unit: RTL

Parametrised instruction fetch stage for the single-cycle/multicycle MIPS datapath. Holds the program counter, an on-block instruction memory with a load port, and a registered instruction output with valid/ready handshake toward decode. It supports stall, branch/jump redirect with flush, and an optional halt state.

---
 rtl/instr_fetch_unit_if.sv | 24 ++
 rtl/instr_fetch_unit.sv | 116 +++++++++++
 2 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-to-decode handshake: registered instruction with valid/ready.
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) ();
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;

    modport master (
        output inst_valid,
        output inst,
        output inst_pc,
        input  inst_ready
    );

    modport slave (
        input  inst_valid,
        input  inst,
        input  inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, loadable instruction memory, registered output toward decode.
// Define FETCH_HALT_EN to enable the halt state machine (stops on an all-ones instruction word).
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W   = 5,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 2 ** ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    instr_fetch_unit_if.master  dec,
    output logic [ADDR_W-1:0]   pc,
    output logic [15:0]         fetch_cnt,
    output logic                halted
);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic [15:0]       cnt_q, cnt_d;

    logic [DATA_W-1:0] fetch_word;
    logic              accept;
    logic              advance;
    logic              halted_w;

    // Memory is deliberately outside reset so a program survives a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign fetch_word = mem[pc_q];
    assign accept     = valid_q & dec.inst_ready;
    assign advance    = !stall && (!valid_q || dec.inst_ready) && !halted_w;

`ifdef FETCH_HALT_EN
    typedef enum logic {StRun, StHalted} state_e;
    state_e state_q, state_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:    if (!redirect_valid && advance && (&fetch_word)) state_d = StHalted;
            StHalted: if (redirect_valid) state_d = StRun;
        endcase
    end

    assign halted_w = (state_q == StHalted);
`else
    assign halted_w = 1'b0;
`endif

    always_comb begin
        pc_d      = pc_q;
        valid_d   = valid_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        // The handshake completes before any flush, so a redirect cycle still counts.
        cnt_d     = cnt_q + 16'(accept);
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;
        end else if (advance) begin
            inst_d    = fetch_word;
            inst_pc_d = pc_q;
            valid_d   = 1'b1;
            pc_d      = pc_q + 1'b1;
        end else if (halted_w && accept) begin
            // While halted the last word is consumed once, then the output goes empty.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q      <= RESET_PC;
            valid_q   <= 1'b0;
            inst_q    <= '0;
            inst_pc_q <= '0;
            cnt_q     <= '0;
        end else begin
            pc_q      <= pc_d;
            valid_q   <= valid_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            cnt_q     <= cnt_d;
        end
    end

    assign dec.inst_valid = valid_q;
    assign dec.inst       = inst_q;
    assign dec.inst_pc    = inst_pc_q;
    assign pc             = pc_q;
    assign fetch_cnt      = cnt_q;
    assign halted         = halted_w;

endmodule
